// File: rtl/fir_stream_pkg.sv
// Shared constants, decimator mode enum and a constant-foldable clog2 for the FIR output path.
package fir_stream_pkg;

    // Must track the filter's output width.
    localparam int unsigned SampleWidth = 16;
    localparam int unsigned DefDecim    = 4;
    localparam int unsigned DefDepth    = 8;

    typedef enum logic {
        DEC_PICK = 1'b0,
        DEC_AVG  = 1'b1
    } dec_mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; dout shows the head, or the last popped word while empty.
module sync_fifo_fwft
    import fir_stream_pkg::*;
#(
    parameter int unsigned WIDTH = SampleWidth,
    parameter int unsigned DEPTH = DefDepth,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level = wr_q - rd_q;

    // A pop frees the slot being written, so a full FIFO still accepts a push alongside a pop.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign dout = empty ? last_q : mem_q[rd_q[AW-1:0]];

    // Pointer and held-output next state; clear overrides any push/pop.
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        last_d = last_q;
        if (clear) begin
            wr_d   = '0;
            rd_d   = '0;
            last_d = '0;
        end else begin
            if (push_ok) begin
                wr_d = wr_q + PtrOne;
            end
            if (pop_ok) begin
                rd_d   = rd_q + PtrOne;
                last_d = mem_q[rd_q[AW-1:0]];
            end
        end
    end

    // Pointer and held-output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            last_q <= last_d;
        end
    end

    // Storage array; contents are only observed after being written.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem_q[wr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fir_output_decimator.sv
// Decimates the filter output by pick or boxcar average and queues results in a FWFT FIFO.
module fir_output_decimator
    import fir_stream_pkg::*;
#(
    parameter int unsigned WIDTH = SampleWidth,
    parameter int unsigned DECIM = DefDecim,
    parameter dec_mode_e   MODE  = DEC_PICK,
    parameter int unsigned DEPTH = DefDepth,
    localparam int unsigned PW   = clog2(DECIM),
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_sample,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sample,
    output logic [AW:0]      fill_level,
    output logic             overflow,
    output logic [7:0]       drop_count
);

    localparam int unsigned AccW      = WIDTH + PW;
    localparam logic [PW-1:0] LastPh  = PW'(DECIM - 1);
    localparam logic [PW-1:0] PhOne   = PW'(1);

    logic [PW-1:0]          phase_q, phase_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             drop_q, drop_d;

    logic signed [AccW-1:0] sample_ext, sum, avg;
    logic                   first_ph, last_ph;
    logic                   push, pop, drop, full, empty;
    logic [WIDTH-1:0]       push_data;

    assign sample_ext = {{PW{in_sample[WIDTH-1]}}, in_sample};
    assign first_ph   = (phase_q == '0);
    assign last_ph    = (phase_q == LastPh);
    // Sum includes the current sample so the group completes on its last phase.
    assign sum        = first_ph ? sample_ext : (acc_q + sample_ext);
    assign avg        = sum >>> PW;

    // Select which accepted sample (or group average) enters the FIFO.
    always_comb begin
        push      = 1'b0;
        push_data = in_sample;
        if (MODE == DEC_AVG) begin
            push      = in_valid && last_ph;
            push_data = avg[WIDTH-1:0];
        end else begin
            push      = in_valid && first_ph;
            push_data = in_sample;
        end
    end

    assign out_valid = !empty;
    assign pop       = !empty && out_ready;
    assign drop      = push && full && !pop;

    // Phase, accumulator and status next state; clear restarts everything.
    always_comb begin
        phase_d    = phase_q;
        acc_d      = acc_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            phase_d    = '0;
            acc_d      = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (in_valid) begin
                phase_d = phase_q + PhOne;
                acc_d   = sum;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
        end
    end

    // Phase, accumulator and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q    <= '0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_q;

    sync_fifo_fwft #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .push (push),
        .pop  (pop),
        .din  (push_data),
        .dout (out_sample),
        .full (full),
        .empty(empty),
        .level(fill_level)
    );

endmodule

// File: tb/tb_fir_output_decimator.sv
// Bench: pick and average instances share stimulus; a queue-based model checks every cycle.
module tb_fir_output_decimator;
    import fir_stream_pkg::*;

    localparam int D = 4;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_sample = '0;

    logic        ov_p, ov_a, of_p, of_a;
    logic [15:0] os_p, os_a;
    logic [3:0]  fl_p, fl_a;
    logic [7:0]  dc_p, dc_a;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    int ph, acc, last_p, last_a, mdc_p, mdc_a;
    bit mof_p, mof_a;
    int q_p[$];
    int q_a[$];
    int log_p[$];
    int log_a[$];

    fir_output_decimator #(.WIDTH(16), .DECIM(D), .MODE(DEC_PICK), .DEPTH(N)) dut_pick (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sample(in_sample),
        .out_valid(ov_p), .out_ready(out_ready), .out_sample(os_p), .fill_level(fl_p),
        .overflow(of_p), .drop_count(dc_p)
    );

    fir_output_decimator #(.WIDTH(16), .DECIM(D), .MODE(DEC_AVG), .DEPTH(N)) dut_avg (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sample(in_sample),
        .out_valid(ov_a), .out_ready(out_ready), .out_sample(os_a), .fill_level(fl_a),
        .overflow(of_a), .drop_count(dc_a)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_log(input string name, input int got[$], input int exp[$]);
        check({name, " count"}, got.size(), exp.size());
        foreach (exp[i]) begin
            if (i < got.size()) check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
        end
    endtask

    task automatic model_reset();
        ph = 0; acc = 0; last_p = 0; last_a = 0; mdc_p = 0; mdc_a = 0;
        mof_p = 0; mof_a = 0;
        q_p.delete(); q_a.delete();
    endtask

    function automatic int floor_div(input int num);
        if (num >= 0) return num / D;
        return -((-num + D - 1) / D);
    endfunction

    // Reference model: updates on every clock edge or async reset assertion.
    initial begin
        int  s, dp, da;
        bit  pp, pa;
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset || clear) begin
                model_reset();
            end else begin
                s = int'($signed(in_sample));
                pp = 0; pa = 0; dp = 0; da = 0;
                if (in_valid) begin
                    if (ph == 0) begin
                        pp = 1; dp = s; acc = s;
                    end else begin
                        acc = acc + s;
                    end
                    if (ph == D - 1) begin
                        pa = 1; da = floor_div(acc);
                    end
                    ph = (ph + 1) % D;
                end
                if (out_ready && q_p.size() > 0) last_p = q_p.pop_front();
                if (pp) begin
                    if (q_p.size() < N) q_p.push_back(dp);
                    else begin mof_p = 1; if (mdc_p < 255) mdc_p++; end
                end
                if (out_ready && q_a.size() > 0) last_a = q_a.pop_front();
                if (pa) begin
                    if (q_a.size() < N) q_a.push_back(da);
                    else begin mof_a = 1; if (mdc_a < 255) mdc_a++; end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("pick out_valid", int'(ov_p), int'(q_p.size() > 0));
        check("pick out_sample", int'($signed(os_p)), (q_p.size() > 0) ? q_p[0] : last_p);
        check("pick fill_level", int'(fl_p), q_p.size());
        check("pick overflow", int'(of_p), int'(mof_p));
        check("pick drop_count", int'(dc_p), mdc_p);
        check("avg out_valid", int'(ov_a), int'(q_a.size() > 0));
        check("avg out_sample", int'($signed(os_a)), (q_a.size() > 0) ? q_a[0] : last_a);
        check("avg fill_level", int'(fl_a), q_a.size());
        check("avg overflow", int'(of_a), int'(mof_a));
        check("avg drop_count", int'(dc_a), mdc_a);
    end

    // Log values actually handed to the consumer.
    initial forever begin
        @(negedge clk);
        if (ov_p && out_ready) log_p.push_back(int'($signed(os_p)));
        if (ov_a && out_ready) log_a.push_back(int'($signed(os_a)));
    end

    task automatic drive(input bit clr, input bit v, input int s, input bit rdy);
        @(posedge clk);
        #2;
        clear = clr; in_valid = v; in_sample = 16'(s); out_ready = rdy;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) drive(0, 0, 0, rdy);
    endtask

    task automatic restart();
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 1);
        log_p.delete(); log_a.delete();
    endtask

    initial begin
        int e[$];
        int f[$];
        int bseq[8];
        int pct;
        bseq = '{-3, -2, -2, -2, 100, 100, 100, 101};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", int'(ov_p), 0);
        check("reset fill_level", int'(fl_a), 0);
        check("reset out_sample", int'(os_p), 0);
        reset = 1'b1;

        // Ramp, pick and average, always ready
        restart();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, i, 1);
            if (i == 1) begin
                @(negedge clk);
                check("A latency valid", int'(ov_p), 1);
                check("A latency sample", int'($signed(os_p)), 0);
            end
        end
        idle(6, 1);
        e = {0, 4, 8, 12};     check_log("A pick", log_p, e);
        f = {1, 5, 9, 13};     check_log("A avg", log_a, f);
        check("A overflow", int'(of_p), 0);

        // Negative floor average
        restart();
        foreach (bseq[i]) drive(0, 1, bseq[i], 1);
        idle(6, 1);
        e = {-3, 100};         check_log("B avg", log_a, e);
        f = {-3, 100};         check_log("B pick", log_p, f);
        check("B avg fill", int'(fl_a), 0);

        // Fill with consumer stalled
        restart();
        for (int i = 0; i < 40; i++) drive(0, 1, i, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("C pick fill", int'(fl_p), 8);
        check("C pick overflow", int'(of_p), 1);
        check("C pick drops", int'(dc_p), 2);
        check("C avg drops", int'(dc_a), 2);
        log_p.delete(); log_a.delete();

        // Full with push and pop together
        drive(0, 1, 40, 1);
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("D pick fill", int'(fl_p), 8);
        check("D pick drops", int'(dc_p), 2);
        check("D avg fill", int'(fl_a), 7);
        idle(12, 1);
        e = {0, 4, 8, 12, 16, 20, 24, 28, 40};  check_log("D pick", log_p, e);
        f = {1, 5, 9, 13, 17, 21, 25, 29};      check_log("D avg", log_a, f);
        check("D overflow sticky", int'(of_p), 1);

        // Gapped input
        restart();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, i, 1);
            drive(0, 0, 1000 + i, 1);
        end
        idle(6, 1);
        e = {0, 4, 8, 12};     check_log("E pick", log_p, e);
        f = {1, 5, 9, 13};     check_log("E avg", log_a, f);

        // Async reset mid-group
        restart();
        for (int i = 0; i < 42; i++) drive(0, 1, i, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("F pre fill", int'(fl_p), 8);
        #2 reset = 1'b0;
        #1;
        check("F rst out_valid", int'(ov_p), 0);
        check("F rst fill", int'(fl_p), 0);
        check("F rst overflow", int'(of_p), 0);
        check("F rst avg fill", int'(fl_a), 0);
        @(negedge clk);
        reset = 1'b1;
        log_p.delete(); log_a.delete();
        drive(0, 1, 77, 1);
        repeat (3) drive(0, 1, 1, 1);
        idle(6, 1);
        e = {77};              check_log("F pick", log_p, e);
        f = {20};              check_log("F avg", log_a, f);

        // Clear wins over a simultaneous push and pop
        for (int i = 0; i < 9; i++) drive(0, 1, i, 0);
        drive(1, 1, 99, 1);
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("G fill", int'(fl_p), 0);
        check("G out_valid", int'(ov_p), 0);
        check("G out_sample", int'(os_p), 0);
        log_p.delete(); log_a.delete();
        drive(0, 1, 55, 1);
        repeat (3) drive(0, 1, 5, 1);
        idle(6, 1);
        e = {55};              check_log("G pick", log_p, e);
        f = {17};              check_log("G avg", log_a, f);

        // Random traffic with varying consumer throughput
        pct = 50;
        for (int c = 0; c < 1200; c++) begin
            if (c % 100 == 0) pct = (c % 300 == 0) ? 10 : ((c % 300 == 100) ? 90 : 50);
            drive($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 65535)), $urandom_range(0, 99) < pct);
        end
        idle(20, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_output_decimator.md
Name: fir_output_decimator

Overview:
- Downstream stage of the FIR filters. Consumes one filtered sample per accepted `in_valid` cycle from `output_signal_y`.
- Decimates by `DECIM`, either by picking one sample or by boxcar-averaging `DECIM` samples.
- Buffers the decimated stream in a small first-word-fall-through (FWFT) FIFO.
- Presents results on a valid/ready interface to the consumer (capture or host readout logic).

Parameters:
- `WIDTH`, 16, sample width in bits, two's complement; matches the filter `width`.
- `DECIM`, 4, decimation factor; power of two, 2..64.
- `MODE`, 0, 0 = pick one sample per group, 1 = average `DECIM` samples per group.
- `DEPTH`, 8, FIFO entries; power of two, 2..64.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous restart: empties the FIFO, zeroes phase/accumulator, clears status.
- `in_valid`  in  1  `in_sample` is meaningful this cycle; tied high when the filter runs every cycle.
- `in_sample`  in  `WIDTH`  signed filter output.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_sample`  out  `WIDTH`  signed decimated sample at the FIFO head.
- `fill_level`  out  clog2(`DEPTH`)+1  current FIFO occupancy.
- `overflow`  out  1  sticky: a decimated sample was dropped because the FIFO was full.
- `drop_count`  out  8  dropped samples; saturates at 255.

Behaviour:
- Reset (`reset`=0, async): all outputs and internal state are 0, i.e. `out_valid`=0, `out_sample`=0, `fill_level`=0, `overflow`=0, `drop_count`=0, phase=0, accumulator=0.
- `clear` has the same effect as reset but synchronously, at the next edge. `clear` takes priority over every push and pop in that cycle.
- Phase counter (clog2(`DECIM`) bits):
  - Advances only on `in_valid`=1.
  - Wraps from `DECIM`-1 to 0.
  - Holds while `in_valid`=0.
- `MODE`=0:
  - The sample accepted at phase 0 is pushed.
  - The other `DECIM`-1 samples are discarded.
  - The first accepted sample after reset or `clear` is pushed.
- `MODE`=1:
  - Accumulator is `WIDTH`+clog2(`DECIM`) bits, sign-extended.
  - Phase 0 loads the sample; later phases add to it.
  - At phase `DECIM`-1 the full sum (including the current sample) is arithmetically shifted right by clog2(`DECIM`), i.e. floor division, and pushed. The accumulator reloads on the next phase 0.
  - Overflow of the accumulator is impossible by construction; no saturation is needed.
- Push timing: a pushed sample is visible at `out_sample` with `out_valid`=1 on the cycle after the push edge when the FIFO was empty (1-cycle latency).
- Pop: occurs when `out_valid`&&`out_ready`. `out_sample` updates to the next entry on the following cycle.
- `out_sample` holds its value while `out_valid`=1 and `out_ready`=0. When the FIFO is empty, `out_sample` holds the last popped value, and `out_valid`=0.
- Full with a push:
  - Without a pop that cycle: the sample is dropped, `overflow` is set, and `drop_count` increments (saturating).
  - With a pop that cycle: the push succeeds and occupancy stays at `DEPTH`.
- Empty with a push: no pop occurs, even if `out_ready`=1; the sample appears the next cycle.
- `fill_level` updates every edge:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop or idle.
- Pointers are clog2(`DEPTH`)+1 bits and wrap naturally; full/empty are decided from the MSB comparison.
- Reset mid-operation aborts the current group; partial accumulations are lost.

Decomposition:
- Package `fir_stream_pkg` holds:
  - the shared sample width constant (same value as the filter width);
  - the default `DECIM`/`DEPTH` constants;
  - the `MODE` enum (`DEC_PICK`, `DEC_AVG`);
  - a `clog2` helper function.
- One sub-module: `sync_fifo_fwft`. It takes `WIDTH` and `DEPTH`; its ports are push, pop, din, dout, full, empty and level.
- The top level holds the phase counter, accumulator, drop logic and status registers.

Test Plan:
- `MODE`=0, `DECIM`=4, `out_ready`=1, input ramp 0,1,2,…,15 → outputs 0,4,8,12, each 1 cycle after its push; `overflow`=0.
- `MODE`=1, `DECIM`=4, inputs −3,−2,−2,−2 then 100,100,100,101 → outputs −3 (floor of −9/4) and 100; `fill_level` returns to 0.
- `MODE`=0, `DEPTH`=8, `out_ready`=0, 40 accepted samples (10 pushes) → `fill_level`=8, `overflow`=1, `drop_count`=2. Then `out_ready`=1 → exactly the first 8 decimated values come out in order.
- Full FIFO with push and pop in the same cycle → no drop, `fill_level` stays 8, and the new sample appears last.
- `in_valid` toggling 1,0,1,0… with the ramp → phase advances only on valid cycles; output identical to the first scenario's sequence.
- Assert `reset`=0 asynchronously mid-group with 3 entries queued → `out_valid`, `fill_level` and `overflow` are 0 immediately. After release, the next accepted sample is pushed as phase 0. A `clear` pulse gives the same result at the next edge.
